// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl
//   Age-ordered, collapsing issue queue. Slot 0 always holds the oldest entry
//   and valid slots are packed into 0..count-1. Each cycle it selects the
//   oldest ready entry for issue, collapses the survivors above it down by one,
//   applies the wakeup broadcast and appends a dispatched entry at the new tail.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every entry at the next edge
//   enq_valid/ready   dispatch handshake; enq_data, enq_tag, enq_rdy describe the entry
//   wk_valid, wk_tag  writeback wakeup broadcast
//   iss_valid/ready   issue handshake; iss_data is the selected payload
//   count             current occupancy
module issue_queue_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic [TAG_W-1:0]           enq_tag,
  input  logic                       enq_rdy,
  input  logic                       wk_valid,
  input  logic [TAG_W-1:0]           wk_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [DATA_W-1:0]          iss_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, rdy_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [DEPTH-1:0]  valid_n, rdy_n;
  logic [TAG_W-1:0]  tag_n  [DEPTH];
  logic [DATA_W-1:0] data_n [DEPTH];
  logic [CNT_W-1:0]  count_n;

  logic              found;
  logic [SEL_W-1:0]  sel;
  logic              iss_fire, enq_fire;
  logic [CNT_W-1:0]  wr_idx;

  // Oldest-first select: scanning down from the top leaves the lowest hit.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy_q[i]) begin
        found = 1'b1;
        sel   = SEL_W'(i);
      end
    end
  end

  assign iss_valid = found;
  assign iss_data  = found ? data_q[sel] : '0;
  assign enq_ready = (count_q < CNT_W'(DEPTH));
  assign count     = count_q;

  assign iss_fire = found & iss_ready;
  assign enq_fire = enq_valid & enq_ready;
  // The tail moves down by one when an issue collapses the queue this cycle.
  assign wr_idx   = count_q - CNT_W'(iss_fire);

  always_comb begin
    valid_n = valid_q;
    rdy_n   = rdy_q;
    tag_n   = tag_q;
    data_n  = data_q;

    // Collapse: everything at or above the issued slot takes its upper neighbour.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (iss_fire && (SEL_W'(i) >= sel)) begin
        valid_n[i] = valid_q[i+1];
        rdy_n[i]   = rdy_q[i+1];
        tag_n[i]   = tag_q[i+1];
        data_n[i]  = data_q[i+1];
      end
    end
    if (iss_fire) begin
      valid_n[DEPTH-1] = 1'b0;
      rdy_n[DEPTH-1]   = 1'b0;
    end

    // Wakeup applies after the shift so moving entries are not missed.
    for (int i = 0; i < DEPTH; i++) begin
      if (wk_valid && valid_n[i] && (tag_n[i] == wk_tag)) begin
        rdy_n[i] = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (CNT_W'(i) == wr_idx)) begin
        valid_n[i] = 1'b1;
        rdy_n[i]   = enq_rdy | (wk_valid && (wk_tag == enq_tag));
        tag_n[i]   = enq_tag;
        data_n[i]  = enq_data;
      end
    end

    case ({enq_fire, iss_fire})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      rdy_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_n;
      rdy_q   <= rdy_n;
      tag_q   <= tag_n;
      data_q  <= data_n;
      count_q <= count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(valid_q) == int'(count_q));
      assert ((valid_q & (valid_q + DEPTH'(1))) == '0);
      assert (!(iss_fire && !iss_valid));
    end
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
module tb_issue_queue_ctrl;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              enq_valid, enq_ready, enq_rdy;
  logic [DATA_W-1:0] enq_data;
  logic [TAG_W-1:0]  enq_tag;
  logic              wk_valid;
  logic [TAG_W-1:0]  wk_tag;
  logic              iss_valid, iss_ready;
  logic [DATA_W-1:0] iss_data;
  logic [4:0]        count;

  int n_pass  = 0;
  int n_total = 0;
  logic [DATA_W-1:0] exp_q[$];

  issue_queue_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_tag(enq_tag), .enq_rdy(enq_rdy),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic r);
    enq_valid = 1'b1;
    enq_data  = d;
    enq_tag   = t;
    enq_rdy   = r;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wake(input logic [TAG_W-1:0] t);
    wk_valid = 1'b1;
    wk_tag   = t;
    tick();
    wk_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag_s, input int c, input logic v, input logic [31:0] d);
    chk({tag_s, "_count"}, 32'(count), 32'(c));
    chk({tag_s, "_iss_valid"}, 32'(iss_valid), 32'(v));
    chk({tag_s, "_iss_data"}, iss_data, d);
  endtask

  // Monitor: every accepted issue outside flush/reset must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !flush && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_issue: got data %0d expected no issue", iss_data);
      end else begin
        chk("issue_data", iss_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    enq_valid = 1'b0; enq_data = '0; enq_tag = '0; enq_rdy = 1'b0;
    wk_valid = 1'b0; wk_tag = '0; iss_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_state("reset", 0, 1'b0, 0);
    chk("reset_enq_ready", 32'(enq_ready), 1);

    // Three ready entries, no issue yet.
    enq(10, 1, 1'b1); enq(11, 2, 1'b1); enq(12, 3, 1'b1);
    chk_state("fill3", 3, 1'b1, 10);
    exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(12);
    iss_ready = 1'b1;
    tick(); tick(); tick();
    iss_ready = 1'b0;
    chk_state("drain3", 0, 1'b0, 0);

    // Oldest entry not ready: younger ready ones bypass it.
    enq(10, 5, 1'b0); enq(11, 1, 1'b1); enq(12, 2, 1'b1);
    chk_state("bypass_pre", 3, 1'b1, 11);
    exp_q.push_back(11); exp_q.push_back(12);
    iss_ready = 1'b1;
    tick();
    chk_state("bypass_1", 2, 1'b1, 12);
    tick();
    chk_state("bypass_2", 1, 1'b0, 0);
    wk_valid = 1'b1; wk_tag = 5;
    chk("wake_latency", 32'(iss_valid), 0);
    tick();
    wk_valid = 1'b0;
    chk_state("woken", 1, 1'b1, 10);
    exp_q.push_back(10);
    tick();
    iss_ready = 1'b0;
    chk_state("woken_done", 0, 1'b0, 0);

    // Fill to DEPTH with non-ready entries; tags 16+k, data 100+k.
    for (int k = 0; k < DEPTH; k++) enq(100 + k, TAG_W'(16 + k), 1'b0);
    chk_state("full", 16, 1'b0, 0);
    chk("full_enq_ready", 32'(enq_ready), 0);
    wake(TAG_W'(16 + 7));
    chk_state("full_woken", 16, 1'b1, 107);
    exp_q.push_back(107);
    iss_ready = 1'b1;
    enq_valid = 1'b1; enq_data = 200; enq_tag = 40; enq_rdy = 1'b0;
    tick();
    iss_ready = 1'b0;
    chk("freed_count", 32'(count), 15);
    chk("freed_enq_ready", 32'(enq_ready), 1);
    tick();
    enq_valid = 1'b0;
    chk("refill_count", 32'(count), 16);
    for (int k = 0; k < DEPTH; k++) wake(TAG_W'(16 + k));
    wake(40);
    for (int k = 0; k < DEPTH; k++) if (k != 7) exp_q.push_back(100 + k);
    exp_q.push_back(200);
    iss_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) tick();
    iss_ready = 1'b0;
    chk_state("order_drain", 0, 1'b0, 0);

    // Same-cycle enqueue + wakeup of its tag + issue of slot 0.
    enq(300, 1, 1'b1); enq(301, 3, 1'b0);
    exp_q.push_back(300);
    iss_ready = 1'b1;
    enq_valid = 1'b1; enq_data = 302; enq_tag = 9; enq_rdy = 1'b0;
    wk_valid = 1'b1; wk_tag = 9;
    tick();
    enq_valid = 1'b0; wk_valid = 1'b0; iss_ready = 1'b0;
    chk_state("same_cycle", 2, 1'b1, 302);
    exp_q.push_back(302);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk_state("same_cycle_done", 1, 1'b0, 0);

    // Flush with 6 entries while both handshakes are active.
    for (int k = 0; k < 5; k++) enq(400 + k, 2, 1'b1);
    chk_state("pre_flush", 6, 1'b1, 400);
    flush = 1'b1; iss_ready = 1'b1;
    enq_valid = 1'b1; enq_data = 500; enq_rdy = 1'b1;
    tick();
    flush = 1'b0; iss_ready = 1'b0; enq_valid = 1'b0;
    chk_state("flush", 0, 1'b0, 0);
    chk("flush_enq_ready", 32'(enq_ready), 1);

    // Same again with reset mid-stream.
    for (int k = 0; k < 6; k++) enq(600 + k, 2, 1'b1);
    chk_state("pre_rst", 6, 1'b1, 600);
    rst = 1'b1; iss_ready = 1'b1;
    enq_valid = 1'b1; enq_data = 700; enq_rdy = 1'b1;
    tick();
    rst = 1'b0; iss_ready = 1'b0; enq_valid = 1'b0;
    chk_state("rst_mid", 0, 1'b0, 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
